dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port round-robin arbiter in front of the word-wide DataMemory (32-bit, sync-read RAM banks).
//   Shares the memory between the CPU load/store unit (port 0) and the AES key/state DMA (port 1).
//   Supports locked bursts so a 4-word AES block transfer is not interleaved.
//   Routes registered read data back to the issuing port after the fixed memory read latency.
// PARAMETERS
//   AW           32  address width (memory decodes a[15:2])
//   DW           32  data width
//   READ_LATENCY 1   cycles from accepted read to valid mem_rd; range 1..3
//   MAX_BURST    4   max consecutive locked grants before forced hand-over
// PORTS
//   clk          in   1   single clock; all state on rising edge
//   reset        in   1   synchronous, active-high reset
//   req0/req1    in   1   access request, held stable with addr/we/wdata until granted
//   we0/we1      in   1   1 = write, 0 = read
//   lock0/lock1  in   1   keep ownership for next beat (burst); sampled only when granted
//   addr0/addr1  in   AW  byte address (word-aligned; a[1:0] ignored downstream)
//   wdata0/wdata1 in  DW  write data
//   gnt0/gnt1    out  1   combinational: this cycle's access is issued to memory
//   rvalid0/rvalid1 out 1 read data valid for this port, one-cycle pulse
//   rdata0/rdata1 out DW  read data; 0 when matching rvalid low
//   mem_a        out  AW  to DataMemory a
//   mem_wd       out  DW  to DataMemory wd
//   mem_we       out  1   to DataMemory we
//   mem_rd       in   DW  from DataMemory rd
// BEHAVIOUR
//   - Accept on port i = req_i & gnt_i; at most one gnt per cycle; gnt only when req.
//   - mem_a/mem_wd/mem_we driven combinationally from granted port; no grant -> all 0.
//   - mem_we = accepted & we of granted port; writes produce no rvalid.
//   - Arbitration: only one requester -> grant it. Both -> grant port != last_owner.
//   - last_owner register updates on every accept.
//   - Lock: if owner accepted with lock_i=1, owner keeps priority next cycle while req_i high.
//   - Lock: burst_cnt counts consecutive locked beats; at MAX_BURST beats, lock ignored for one arbitration.
//   - Lock: other port wins that arbitration if requesting.
//   - Lock: lock dropped or req_i low -> burst_cnt cleared, normal round-robin.
//   - Read return: accepted read pushes {1,id} into READ_LATENCY-deep tag shift register.
//   - Read return: at tail, rvalid_id=1 and rdata_id=mem_rd exactly READ_LATENCY cycles after accept.
//   - Back-to-back reads from either port fully pipelined: one read per cycle, in order.
//   - Read-after-write same address on consecutive cycles returns new data (memory is write-first).
//   - Arbiter adds no hazard logic.
//   - Reset (any cycle, incl. mid-burst / reads in flight):
//       gnt*=0 comb., rvalid*=0, rdata*=0, tag pipe cleared (in-flight reads dropped).
//       burst_cnt=0, last_owner=1 (port 0 wins first contention).
//   - reset held high: no gnt even if req, mem_we=0.
// STRUCTURE
//   - Package dmem_arb_pkg: PORT_CPU=0, PORT_AES=1 localparams.
//   - Package dmem_arb_pkg: typedef rd_tag_t {logic vld; logic id;}.
//   - Package dmem_arb_pkg: DW/AW defaults.
//   - Sub-module dmem_rd_tag_pipe: parameterised READ_LATENCY shift register of rd_tag_t with sync clear.
//   - Top holds arbitration comb logic, last_owner, burst_cnt, output muxing.
// TESTING
//   1 req0 read 0x10 alone (mem[4]=0xA5A5_0001) -> gnt0 same cycle.
//     Next cycle rvalid0=1, rdata0=0xA5A5_0001, rvalid1=0.
//   2 req0&req1 every cycle, no lock, after reset -> grants 0,1,0,1...
//   3 port1 locked burst, 6 beats, addr 0x20..0x34; req0 contending.
//     Grants 1,1,1,1,0,1...; lock ignored after 4th beat.
//   4 write 0x40=0xDEAD_BEEF by port1, then port0 read 0x40 next cycle -> rdata0=0xDEAD_BEEF, no rvalid1.
//   5 Alternating reads p0/p1, READ_LATENCY=2 -> rvalid returns in issue order, correct port, 2-cycle lag.
//   6 Reset asserted with 1 read in flight and mid-burst.
//     Next cycle rvalid*=0; after release port0 wins contention.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port identifiers, default widths and the read-return tag.
package dmem_arb_pkg;

  localparam int DMEM_AW = 32;
  localparam int DMEM_DW = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AES = 1'b1;

  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and DataMemory.
// slave = arbiter view, master = requesters plus memory view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = DMEM_AW,
  parameter int DW = DMEM_DW
);

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic          lock0;
  logic          lock1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  req0, req1,
    input  we0, we1,
    input  lock0, lock1,
    input  addr0, addr1,
    input  wdata0, wdata1,
    input  mem_rd,
    output gnt0, gnt1,
    output rvalid0, rvalid1,
    output rdata0, rdata1,
    output mem_a, mem_wd, mem_we
  );

  modport master (
    output req0, req1,
    output we0, we1,
    output lock0, lock1,
    output addr0, addr1,
    output wdata0, wdata1,
    output mem_rd,
    input  gnt0, gnt1,
    input  rvalid0, rvalid1,
    input  rdata0, rdata1,
    input  mem_a, mem_wd, mem_we
  );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Read-return tag delay line matching the memory read latency.
// Tail entry marks which port owns the data now on mem_rd.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic    clk,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with locked bursts in front of DataMemory.
// Grants are combinational; read data is steered back by a tag pipe.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = DMEM_AW,
  parameter int DW           = DMEM_DW,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]    req;
  logic [1:0]    lock;
  logic [1:0]    we;
  logic [1:0]    gnt;
  logic          sel;
  logic          acc;
  logic          lock_act;
  logic          last_owner_q;
  logic          last_owner_d;
  logic [CW-1:0] burst_cnt_q;
  logic [CW-1:0] burst_cnt_d;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;
  logic          rv0;
  logic          rv1;

  assign req  = {bus.req1, bus.req0} & {2{~reset}};
  assign lock = {bus.lock1, bus.lock0};
  assign we   = {bus.we1, bus.we0};

  // Owner keeps priority until the burst hits MAX_BURST beats.
  assign lock_act = (burst_cnt_q != '0)
                  && (burst_cnt_q < BMAX)
                  && req[last_owner_q];

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      lock_act:
        gnt[last_owner_q] = 1'b1;
      (!lock_act && req == 2'b11):
        gnt[~last_owner_q] = 1'b1;
      (!lock_act && req == 2'b01):
        gnt[0] = 1'b1;
      (!lock_act && req == 2'b10):
        gnt[1] = 1'b1;
      default: ;
    endcase
  end

  assign acc = |gnt;
  assign sel = gnt[1];

  assign addr_sel  = sel ? bus.addr1 : bus.addr0;
  assign wdata_sel = sel ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0   = gnt[0];
  assign bus.gnt1   = gnt[1];
  assign bus.mem_a  = acc ? addr_sel : '0;
  assign bus.mem_wd = acc ? wdata_sel : '0;
  assign bus.mem_we = acc & we[sel];

  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    if (acc) begin
      last_owner_d = sel;
      if (lock[sel]) begin
        if (sel == last_owner_q && lock_act) begin
          burst_cnt_d = burst_cnt_q + ONE;
        end else begin
          burst_cnt_d = ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= PORT_AES;
      burst_cnt_q  <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = acc & ~we[sel];
    tag_in.id  = sel;
  end

  dmem_rd_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .clr_i(reset),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  // Data already on mem_rd during reset belongs to a dropped read.
  assign rv0 = tag_out.vld & (tag_out.id == PORT_CPU) & ~reset;
  assign rv1 = tag_out.vld & (tag_out.id == PORT_AES) & ~reset;

  assign bus.rvalid0 = rv0;
  assign bus.rvalid1 = rv1;
  assign bus.rdata0  = rv0 ? bus.mem_rd : '0;
  assign bus.rdata1  = rv1 ? bus.mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 2) on one stimulus.
// Expected reads are queued per instance and matched by a monitor.
module tb_dmem_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  logic wr40;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    int          inst;
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] mema [256];
  logic [31:0] memb [256];
  logic [31:0] pa [2];
  logic [31:0] pb [2];

  dmem_arbiter_if #(.AW(32), .DW(32)) ifa ();
  dmem_arbiter_if #(.AW(32), .DW(32)) ifb ();

  dmem_arbiter #(
    .AW(32), .DW(32), .READ_LATENCY(1), .MAX_BURST(4)
  ) u_dut_l1 (
    .clk(clk), .reset(rst), .bus(ifa.slave)
  );

  dmem_arbiter #(
    .AW(32), .DW(32), .READ_LATENCY(2), .MAX_BURST(4)
  ) u_dut_l2 (
    .clk(clk), .reset(rst), .bus(ifb.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] iw(input logic [31:0] a);
    if (a[9:2] == 8'd4) return 32'hA5A5_0001;
    return {16'hC0DE, 8'h00, a[9:2]};
  endfunction

  function automatic logic [31:0] ew(input logic [31:0] a);
    if (wr40 && a == 32'h40) return 32'hDEAD_BEEF;
    return iw(a);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Write-first, sync-read memory models with 1 and 2 cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mema[i] <= iw(32'(i * 4));
    end else if (ifa.mem_we) begin
      mema[ifa.mem_a[9:2]] <= ifa.mem_wd;
    end
    pa[0] <= ifa.mem_we ? ifa.mem_wd : mema[ifa.mem_a[9:2]];
    pa[1] <= pa[0];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) memb[i] <= iw(32'(i * 4));
    end else if (ifb.mem_we) begin
      memb[ifb.mem_a[9:2]] <= ifb.mem_wd;
    end
    pb[0] <= ifb.mem_we ? ifb.mem_wd : memb[ifb.mem_a[9:2]];
    pb[1] <= pb[0];
  end

  assign ifa.mem_rd = pa[0];
  assign ifb.mem_rd = pb[1];

  task automatic drv(
    input logic r0, w0, k0, input logic [31:0] a0, d0,
    input logic r1, w1, k1, input logic [31:0] a1, d1
  );
    ifa.req0 = r0; ifa.we0 = w0; ifa.lock0 = k0;
    ifa.addr0 = a0; ifa.wdata0 = d0;
    ifa.req1 = r1; ifa.we1 = w1; ifa.lock1 = k1;
    ifa.addr1 = a1; ifa.wdata1 = d1;
    ifb.req0 = r0; ifb.we0 = w0; ifb.lock0 = k0;
    ifb.addr0 = a0; ifb.wdata0 = d0;
    ifb.req1 = r1; ifb.we1 = w1; ifb.lock1 = k1;
    ifb.addr1 = a1; ifb.wdata1 = d1;
  endtask

  task automatic beat(
    input string nm, input logic [1:0] eg,
    input logic r0, w0, k0, input logic [31:0] a0, d0,
    input logic r1, w1, k1, input logic [31:0] a1, d1
  );
    logic [1:0]  g;
    logic [1:0]  rv;
    logic [64:0] mx;
    logic [64:0] mw;
    drv(r0, w0, k0, a0, d0, r1, w1, k1, a1, d1);
    @(negedge clk);
    mw = '0;
    if (eg == 2'b01) mw = {w0, a0, d0};
    if (eg == 2'b10) mw = {w1, a1, d1};
    for (int k = 0; k < 2; k++) begin
      g  = k != 0 ? {ifb.gnt1, ifb.gnt0} : {ifa.gnt1, ifa.gnt0};
      rv = k != 0 ? {ifb.rvalid1, ifb.rvalid0}
                  : {ifa.rvalid1, ifa.rvalid0};
      mx = k != 0 ? {ifb.mem_we, ifb.mem_a, ifb.mem_wd}
                  : {ifa.mem_we, ifa.mem_a, ifa.mem_wd};
      n_cmp++;
      if (g !== eg) begin
        n_bad++;
        $display("FAIL %s dut%0d gnt got %b want %b", nm, k, g, eg);
      end
      n_cmp++;
      if (mx !== mw) begin
        n_bad++;
        $display("FAIL %s dut%0d mem we/a/wd got %h want %h",
                 nm, k, mx, mw);
      end
      if (rst) begin
        n_cmp++;
        if (rv !== 2'b00) begin
          n_bad++;
          $display("FAIL %s dut%0d rvalid in reset got %b want 00",
                   nm, k, rv);
        end
      end
      if (eg == 2'b01 && !w0)
        sbq.push_back('{inst: k, port: 1'b0, data: ew(a0),
                        due: cyc + lat(k)});
      if (eg == 2'b10 && !w1)
        sbq.push_back('{inst: k, port: 1'b1, data: ew(a1),
                        due: cyc + lat(k)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat("idle", 2'b00, N, N, N, Z, Z, N, N, N, Z, Z);
  endtask

  // Reads still in the pipe when reset hits are dropped by the DUT.
  task automatic flush();
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due >= cyc) sbq.delete(i);
    end
  endtask

  task automatic mon(
    input int k, input logic v0, v1, input logic [31:0] d0, d1
  );
    int          idx;
    logic [31:0] got;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) begin
      if (idx < 0 && sbq[i].inst == k) idx = i;
    end
    n_cmp++;
    if ((!v0 && d0 != 0) || (!v1 && d1 != 0)) begin
      n_bad++;
      $display("FAIL rdata_idle dut%0d got %h/%h want 0", k, d0, d1);
    end
    got = v1 ? d1 : d0;
    if (v0 || v1) begin
      n_cmp++;
      if (v0 && v1) begin
        n_bad++;
        $display("FAIL rvalid_both dut%0d cyc %0d", k, cyc);
      end else if (idx < 0) begin
        n_bad++;
        $display("FAIL rd_unexp dut%0d port %0d data %h cyc %0d want none",
                 k, v1, got, cyc);
      end else begin
        if (sbq[idx].port !== v1 || sbq[idx].data !== got
            || sbq[idx].due != cyc) begin
          n_bad++;
          $display("FAIL rd_ret dut%0d got p%0d %h @%0d want p%0d %h @%0d",
                   k, v1, got, cyc, sbq[idx].port, sbq[idx].data,
                   sbq[idx].due);
        end
        sbq.delete(idx);
      end
    end else if (idx >= 0 && sbq[idx].due <= cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_missing dut%0d got none want p%0d %h @%0d",
               k, sbq[idx].port, sbq[idx].data, sbq[idx].due);
      sbq.delete(idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst     = 1'b1;
    preload = 1'b1;
    wr40    = 1'b0;
    n_cmp   = 0;
    n_bad   = 0;
    drv(N, N, N, Z, Z, N, N, N, Z, Z);
    fork
      forever begin
        @(negedge clk);
        mon(0, ifa.rvalid0, ifa.rvalid1, ifa.rdata0, ifa.rdata1);
        mon(1, ifb.rvalid0, ifb.rvalid1, ifb.rdata0, ifb.rdata1);
      end
    join_none
    @(posedge clk);
    #1;
    preload = 1'b0;

    beat("rst_gnt", 2'b00, Y, N, N, 32'h10, Z, Y, N, N, 32'h20, Z);
    rst = 1'b0;

    beat("t1_rd", 2'b01, Y, N, N, 32'h10, Z, N, N, N, Z, Z);
    idle(2);

    rst = 1'b1;
    flush();
    beat("rst2", 2'b00, N, N, N, Z, Z, N, N, N, Z, Z);
    rst = 1'b0;

    beat("t2_rr0", 2'b01, Y, N, N, 32'h00, Z, Y, N, N, 32'h80, Z);
    beat("t2_rr1", 2'b10, Y, N, N, 32'h04, Z, Y, N, N, 32'h80, Z);
    beat("t2_rr2", 2'b01, Y, N, N, 32'h04, Z, Y, N, N, 32'h84, Z);
    beat("t2_rr3", 2'b10, Y, N, N, 32'h08, Z, Y, N, N, 32'h84, Z);
    idle(2);

    beat("t3_b1", 2'b10, N, N, N, Z, Z, Y, N, Y, 32'h20, Z);
    beat("t3_b2", 2'b10, Y, N, N, 32'h50, Z, Y, N, Y, 32'h24, Z);
    beat("t3_b3", 2'b10, Y, N, N, 32'h50, Z, Y, N, Y, 32'h28, Z);
    beat("t3_b4", 2'b10, Y, N, N, 32'h50, Z, Y, N, Y, 32'h2C, Z);
    beat("t3_hand", 2'b01, Y, N, N, 32'h50, Z, Y, N, Y, 32'h30, Z);
    beat("t3_b5", 2'b10, N, N, N, Z, Z, Y, N, Y, 32'h30, Z);
    beat("t3_b6", 2'b10, N, N, N, Z, Z, Y, N, N, 32'h34, Z);
    idle(2);

    beat("t4_wr", 2'b10, N, N, N, Z, Z, Y, Y, N, 32'h40, 32'hDEAD_BEEF);
    wr40 = 1'b1;
    beat("t4_raw", 2'b01, Y, N, N, 32'h40, Z, N, N, N, Z, Z);
    idle(2);

    beat("t5_a0", 2'b10, Y, N, N, 32'h60, Z, Y, N, N, 32'h70, Z);
    beat("t5_a1", 2'b01, Y, N, N, 32'h60, Z, Y, N, N, 32'h74, Z);
    beat("t5_a2", 2'b10, Y, N, N, 32'h64, Z, Y, N, N, 32'h74, Z);
    beat("t5_a3", 2'b01, Y, N, N, 32'h64, Z, Y, N, N, 32'h78, Z);
    beat("t5_p0", 2'b01, Y, N, N, 32'h00, Z, N, N, N, Z, Z);
    beat("t5_p1", 2'b01, Y, N, N, 32'h04, Z, N, N, N, Z, Z);
    beat("t5_p2", 2'b01, Y, N, N, 32'h08, Z, N, N, N, Z, Z);
    idle(3);

    beat("t6_b1", 2'b10, N, N, N, Z, Z, Y, N, Y, 32'h20, Z);
    beat("t6_b2", 2'b10, Y, N, N, 32'h10, Z, Y, N, Y, 32'h24, Z);
    rst = 1'b1;
    flush();
    beat("t6_rst", 2'b00, Y, N, N, 32'h10, Z, Y, N, Y, 32'h28, Z);
    rst = 1'b0;
    beat("t6_win0", 2'b01, Y, N, N, 32'h10, Z, Y, N, Y, 32'h28, Z);
    beat("t6_p1", 2'b10, N, N, N, Z, Z, Y, N, N, 32'h28, Z);
    idle(3);

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
